// File: rtl/mux_scan.sv
// mux_scan: registered N-channel multiplexer with a manual/scan sequencer and a valid/ready output.
// Define SCAN_MASK_EN to add a ch_mask input that limits which channels a scan visits.
module mux_scan #(
  parameter int N_CH  = 4,
  parameter int W     = 1,
  parameter int DWELL = 1,
  localparam int SELW = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] din,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic              start,
`ifdef SCAN_MASK_EN
  input  logic [N_CH-1:0]   ch_mask,
`endif
  input  logic              out_ready,
  output logic [W-1:0]      dout,
  output logic [SELW-1:0]   ch,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, OUT} state_t;

  state_t          state_reg, state_next;
  logic [SELW-1:0] ch_reg, ch_next;
  logic [W-1:0]    dout_reg, dout_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            mode_reg, mode_next;
  logic            done_reg, done_next;

  logic [N_CH-1:0] start_mask;
  logic [N_CH-1:0] active_mask;
  logic [SELW-1:0] first_ch;
  logic            any_set;
  logic [SELW-1:0] next_ch;
  logic            has_next;

  logic [W-1:0] chan [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      assign chan[gi] = din[gi*W +: W];
    end
  endgenerate

`ifdef SCAN_MASK_EN
  logic [N_CH-1:0] mask_reg, mask_next;
  assign start_mask  = ch_mask;
  assign active_mask = mask_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) mask_reg <= '0;
    else        mask_reg <= mask_next;
  end
`else
  assign start_mask  = '1;
  assign active_mask = '1;
`endif

  // Lowest enabled channel at start, and the next enabled channel above the current one.
  always_comb begin
    first_ch = '0;
    any_set  = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (start_mask[i]) begin
        first_ch = SELW'(i);
        any_set  = 1'b1;
      end
    end
    next_ch  = '0;
    has_next = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (active_mask[i] && (i > int'(ch_reg))) begin
        next_ch  = SELW'(i);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    dout_next  = dout_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    done_next  = 1'b0;
`ifdef SCAN_MASK_EN
    mask_next  = mask_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (!mode) begin
            // Out-of-range channel requests are dropped without side effects.
            if (int'(sel) < N_CH) begin
              mode_next  = 1'b0;
              ch_next    = sel;
              cnt_next   = CNT_LOAD;
              state_next = SAMPLE;
            end
          end else begin
`ifdef SCAN_MASK_EN
            mask_next = start_mask;
`endif
            if (any_set) begin
              mode_next  = 1'b1;
              ch_next    = first_ch;
              cnt_next   = CNT_LOAD;
              state_next = SAMPLE;
            end else begin
              done_next = 1'b1;
            end
          end
        end
      end
      SAMPLE: begin
        if (cnt_reg == '0) begin
          dout_next  = chan[ch_reg];
          state_next = OUT;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (mode_reg && has_next) begin
            ch_next    = next_ch;
            cnt_next   = CNT_LOAD;
            state_next = SAMPLE;
          end else begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
      dout_reg  <= '0;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      dout_reg  <= dout_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      done_reg  <= done_next;
    end
  end

  assign dout      = dout_reg;
  assign ch        = ch_reg;
  assign out_valid = (state_reg == OUT);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

endmodule
